// File: rtl/sys_bus_arbiter_pkg.sv
// Shared definitions for the system bus arbiter: default widths, FSM state
// encoding and an index-width helper.
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 8
`endif
`ifndef MEM_WIDTH
`define MEM_WIDTH 32
`endif

package sys_bus_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = `ADDR_BUS_WIDTH;
  localparam int unsigned DATA_W_DEF = `MEM_WIDTH;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_ALE  = 3'd1,
    S_WR   = 3'd2,
    S_RD   = 3'd3,
    S_CAPT = 3'd4,
    S_DONE = 3'd5
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sys_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request searching upward
// from last+1 with wrap-around.
module rr_pick
  import sys_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               vld_c,
  output logic [IDX_W-1:0]   idx_c
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate down so the nearest one after last wins.
  always_comb begin
    vld_c = 1'b0;
    idx_c = '0;
    cand  = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % int'(NUM_REQ));
      if (req[cand]) begin
        vld_c = 1'b1;
        idx_c = cand;
      end
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter and phase sequencer for the shared address/data bus.
// Sequence per transfer: ALE, then WR (write) or RD+CAPT (read), then DONE.
// Optional macro SYS_BUS_ARB_LOCK_EN adds req_lock for back-to-back
// transfers by the granted requester without returning to IDLE.
module sys_bus_arbiter
  import sys_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
`ifdef SYS_BUS_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      bus_ale_en,
  output logic                      bus_read_en,
  output logic                      bus_write_en,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  input  logic [DATA_W-1:0]         bus_rdata,
  output logic                      busy
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]    last_q, last_d;

  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic                load_en;
  logic [IDX_W-1:0]    load_idx;

  logic [NUM_REQ-1:0]  gnt_d, ack_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                ale_d, rd_d, wr_d, busy_d;
  logic [ADDR_W-1:0]   bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_d;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .vld_c (pick_vld),
    .idx_c (pick_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state, request latching and registered output decode of next state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    last_d      = last_q;
    rdata_d     = rdata;
    load_en     = 1'b0;
    load_idx    = pick_idx;
    gnt_d       = '0;
    ack_d       = '0;
    ale_d       = 1'b0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    bus_addr_d  = '0;
    bus_wdata_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          load_en = 1'b1;
          state_d = S_ALE;
        end
      end
      S_ALE:  state_d = we_q ? S_WR : S_RD;
      S_WR:   state_d = S_DONE;
      S_RD:   state_d = S_CAPT;
      S_CAPT: begin
        rdata_d = bus_rdata;
        state_d = S_DONE;
      end
      S_DONE: begin
        last_d  = idx_q;
        state_d = S_IDLE;
`ifdef SYS_BUS_ARB_LOCK_EN
        if (req_lock[idx_q] && req[idx_q]) begin
          load_en  = 1'b1;
          load_idx = idx_q;
          state_d  = S_ALE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (load_en) begin
      idx_d   = load_idx;
      we_d    = req_we[load_idx];
      addr_d  = req_addr[int'(load_idx)*int'(ADDR_W) +: ADDR_W];
      wdata_d = req_wdata[int'(load_idx)*int'(DATA_W) +: DATA_W];
    end

    busy_d = (state_d != S_IDLE);
    if (busy_d) begin
      gnt_d[idx_d] = 1'b1;
      bus_addr_d   = addr_d;
    end

    case (state_d)
      S_ALE:  ale_d = 1'b1;
      S_WR: begin
        wr_d        = 1'b1;
        bus_wdata_d = wdata_d;
      end
      S_RD:   rd_d = 1'b1;
      S_DONE: ack_d[idx_d] = 1'b1;
      default: ;
    endcase
  end

  // Latched request fields, round-robin pointer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_q       <= IDX_W'(NUM_REQ - 1);
      gnt          <= '0;
      ack          <= '0;
      rdata        <= '0;
      bus_ale_en   <= 1'b0;
      bus_read_en  <= 1'b0;
      bus_write_en <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      busy         <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_q       <= last_d;
      gnt          <= gnt_d;
      ack          <= ack_d;
      rdata        <= rdata_d;
      bus_ale_en   <= ale_d;
      bus_read_en  <= rd_d;
      bus_write_en <= wr_d;
      bus_addr     <= bus_addr_d;
      bus_wdata    <= bus_wdata_d;
      busy         <= busy_d;
    end
  end

endmodule
